// File: rtl/piso_pkg.sv
// Shared types and sizing for the piso_tx serialiser.
// Build option: define PISO_TX_PARITY_EN to append an even-parity bit to every word.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

`ifdef PISO_TX_PARITY_EN
    localparam bit PISO_PARITY = 1'b1;
`else
    localparam bit PISO_PARITY = 1'b0;
`endif

    // Serial bits per word: the data bits plus the optional trailing parity bit.
    function automatic int piso_nbits(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Word handshake and serial output bundle for piso_tx.
// master = upstream word source, slave = the serialiser.
interface piso_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             q;
    logic             qbar;
    logic             frame;
    logic             busy;

    modport master (
        output din, din_valid,
        input  din_ready, q, qbar, frame, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, q, qbar, frame, busy
    );
endinterface

// File: rtl/piso_bit_cnt.sv
// Loadable bit-position counter for piso_tx; tc flags the last bit of a word.
module piso_bit_cnt #(
    parameter int CW   = 4,
    parameter int LAST = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign cnt = cnt_reg;
    assign tc  = (cnt_reg == CW'(LAST));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one bit per clock, words stream back-to-back.
// Build option: PISO_TX_PARITY_EN appends an even-parity bit after the data bits.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic     clk,
    input  logic     rst,
    piso_tx_if.slave bus
);
    localparam int NBITS = piso_nbits(WIDTH, PISO_PARITY);
    localparam int CW    = $clog2(WIDTH + 1);

    piso_state_t      state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic             par_reg, par_next;
    logic             q_reg, q_next;
    logic             qbar_reg;
    logic             frame_reg, frame_next;
    logic             busy_reg, busy_next;

    logic [CW-1:0]    cnt;
    logic             tc;
    logic             cnt_load;
    logic             cnt_en;
    logic             din_ready;
    logic             accept;
    logic             sr_bit;
    logic [WIDTH-1:0] sr_shifted;
    logic             din_first;
    logic [WIDTH-1:0] din_rest;

    piso_bit_cnt #(
        .CW   (CW),
        .LAST (NBITS - 1)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .cnt  (cnt),
        .tc   (tc)
    );

    // Ready depends only on registered state so upstream sees no path from din_valid.
    assign din_ready = (state_reg == IDLE) || ((state_reg == SHIFT) && tc);
    assign accept    = bus.din_valid && din_ready;

    // The register holds only the bits not yet sent; the first bit goes straight to q.
    always_comb begin
        if (MSB_FIRST != 0) begin
            din_first  = bus.din[WIDTH-1];
            din_rest   = {bus.din[WIDTH-2:0], 1'b0};
            sr_bit     = sr_reg[WIDTH-1];
            sr_shifted = {sr_reg[WIDTH-2:0], 1'b0};
        end else begin
            din_first  = bus.din[0];
            din_rest   = {1'b0, bus.din[WIDTH-1:1]};
            sr_bit     = sr_reg[0];
            sr_shifted = {1'b0, sr_reg[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        par_next   = par_reg;
        q_next     = 1'b0;
        frame_next = 1'b0;
        busy_next  = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        if (accept) begin
            state_next = SHIFT;
            sr_next    = din_rest;
            par_next   = PISO_PARITY ? ^bus.din : 1'b0;
            q_next     = din_first;
            frame_next = 1'b1;
            busy_next  = 1'b1;
            cnt_load   = 1'b1;
        end else if (state_reg == SHIFT) begin
            if (tc) begin
                state_next = IDLE;
                sr_next    = '0;
                cnt_load   = 1'b1;
            end else begin
                // After the last data bit the stored parity takes the line.
                q_next     = (PISO_PARITY && (cnt == CW'(WIDTH - 1))) ? par_reg : sr_bit;
                sr_next    = sr_shifted;
                frame_next = 1'b1;
                busy_next  = 1'b1;
                cnt_en     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            par_reg   <= 1'b0;
            q_reg     <= 1'b0;
            qbar_reg  <= 1'b1;
            frame_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            par_reg   <= par_next;
            q_reg     <= q_next;
            qbar_reg  <= ~q_next;
            frame_reg <= frame_next;
            busy_reg  <= busy_next;
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.q         = q_reg;
    assign bus.qbar      = qbar_reg;
    assign bus.frame     = frame_reg;
    assign bus.busy      = busy_reg;

endmodule
